// File: rtl/usb_tx_pkg.sv
// Shared state encoding and USB framing constants for the full-speed TX timing controller.
package usb_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_EOP
  } tx_state_e;

  localparam int SYNC_BITS    = 8;
  localparam int EOP_SE0_BITS = 2;
  localparam int EOP_BITS     = 3;

endpackage

// File: rtl/tx_bit_timer.sv
// Bit-period timer: counts system clocks within one USB bit and strobes on the last one.
module tx_bit_timer #(
  parameter int CLKS_PER_BIT = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic bit_strobe
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!n_rst || clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    end
  end

  assign bit_strobe = en && (cnt == CNT_LAST);

endmodule

// File: rtl/usb_tx_timing_ctrl.sv
// USB full-speed transmit sequencer: SYNC, byte loading with bit-stuff slots, EOP, abort and
// underrun detection, all timed from a shared bit-period strobe.
module usb_tx_timing_ctrl
  import usb_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT  = 8,
  parameter int BITS_PER_BYTE = 8
) (
  input  logic clk,
  input  logic n_rst,
  input  logic start,
  input  logic byte_valid,
  input  logic last_byte,
  input  logic stuff_req,
  input  logic abort,
  output logic bit_strobe,
  output logic load_byte,
  output logic stuff_slot,
  output logic sync_active,
  output logic eop_se0,
  output logic eop_j,
  output logic busy,
  output logic done,
  output logic underrun_err
);

  localparam int BCW = (BITS_PER_BYTE > 1) ? $clog2(BITS_PER_BYTE) : 1;
  localparam logic [BCW-1:0] BYTE_LAST = BCW'(BITS_PER_BYTE - 1);
  localparam logic [BCW-1:0] SYNC_LAST = BCW'(SYNC_BITS - 1);
  localparam logic [BCW-1:0] SE0_END   = BCW'(EOP_SE0_BITS);
  localparam logic [BCW-1:0] EOP_LAST  = BCW'(EOP_BITS - 1);

  tx_state_e      state;
  tx_state_e      state_nxt;
  logic [BCW-1:0] bit_cnt;
  logic [BCW-1:0] bit_last;
  logic           stuff_q;
  logic           pend_q;
  logic           last_q;
  logic           uerr_q;
  logic           strobe;
  logic           idle;
  logic           active;
  logic           at_last;
  logic           boundary;
  logic           take_byte;
  logic           eop_end;

  assign idle     = (state == ST_IDLE);
  assign active   = (state == ST_SYNC) || (state == ST_DATA);
  assign bit_last = (state == ST_SYNC) ? SYNC_LAST : BYTE_LAST;
  assign at_last  = (bit_cnt == bit_last);
  // A stuff request on the final bit pushes the byte boundary to the end of the stuff slot.
  assign boundary  = strobe && active && (stuff_q ? pend_q : (at_last && !stuff_req));
  assign take_byte = boundary && !abort && ((state == ST_SYNC) || !last_q);
  assign eop_end   = strobe && (state == ST_EOP) && (bit_cnt == EOP_LAST);

  tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .clk       (clk),
    .n_rst     (n_rst),
    .clr       (idle),
    .en        (!idle),
    .bit_strobe(strobe)
  );

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_SYNC;
      end
      ST_SYNC, ST_DATA: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (boundary) begin
          if ((state == ST_DATA) && last_q) state_nxt = ST_EOP;
          else if (byte_valid)              state_nxt = ST_DATA;
          else                              state_nxt = ST_IDLE;
        end
      end
      ST_EOP: begin
        if (abort || eop_end) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!n_rst) begin
      bit_cnt <= '0;
      stuff_q <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      uerr_q  <= 1'b0;
    end else if (idle || abort) begin
      bit_cnt <= '0;
      stuff_q <= 1'b0;
      pend_q  <= 1'b0;
      last_q  <= 1'b0;
      if (idle && start) uerr_q <= 1'b0;
    end else begin
      if (strobe) begin
        if (stuff_q) begin
          stuff_q <= 1'b0;
          pend_q  <= 1'b0;
        end else begin
          bit_cnt <= at_last ? '0 : bit_cnt + 1'b1;
          if (active && stuff_req) begin
            stuff_q <= 1'b1;
            pend_q  <= at_last;
          end
        end
      end
      if (take_byte && byte_valid)  last_q <= last_byte;
      if (take_byte && !byte_valid) uerr_q <= 1'b1;
    end
  end

  always_comb begin
    busy         = !idle;
    sync_active  = (state == ST_SYNC);
    stuff_slot   = stuff_q && active;
    eop_se0      = (state == ST_EOP) && (bit_cnt < SE0_END);
    eop_j        = (state == ST_EOP) && !(bit_cnt < SE0_END);
    bit_strobe   = strobe;
    load_byte    = take_byte && byte_valid;
    done         = eop_end && !abort;
    underrun_err = uerr_q;
  end

endmodule

// File: tb/tb_usb_tx_timing_ctrl.sv
// Bench for usb_tx_timing_ctrl: directed packets, output change points scoreboarded by cycle.
module tb_usb_tx_timing_ctrl;

  logic clk = 1'b0;
  logic n_rst = 1'b0;
  logic start = 1'b0;
  logic byte_valid = 1'b0;
  logic last_byte = 1'b0;
  logic stuff_req = 1'b0;
  logic abort = 1'b0;
  logic bit_strobe, load_byte, stuff_slot, sync_active, eop_se0, eop_j, busy, done, underrun_err;

  typedef struct {
    int         cyc;
    logic [7:0] vec;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       me;
  logic [7:0] mv;
  logic [7:0] prev_vec = 8'h00;
  logic       mon_en = 1'b0;
  int         checks = 0;
  int         failures = 0;
  int         pos_cnt = 0;
  int         base = 0;
  int         rel = 0;
  int         strobe_cnt = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pos_cnt <= pos_cnt + 1;

  usb_tx_timing_ctrl #(
    .CLKS_PER_BIT (8),
    .BITS_PER_BYTE(8)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .byte_valid  (byte_valid),
    .last_byte   (last_byte),
    .stuff_req   (stuff_req),
    .abort       (abort),
    .bit_strobe  (bit_strobe),
    .load_byte   (load_byte),
    .stuff_slot  (stuff_slot),
    .sync_active (sync_active),
    .eop_se0     (eop_se0),
    .eop_j       (eop_j),
    .busy        (busy),
    .done        (done),
    .underrun_err(underrun_err)
  );

  // Vector order: busy sync stuff se0 j uerr load done
  function automatic logic [7:0] out_vec();
    return {busy, sync_active, stuff_slot, eop_se0, eop_j, underrun_err, load_byte, done};
  endfunction

  task automatic expect_at(input int c, input logic [7:0] v);
    exp_t e;
    e.cyc = c;
    e.vec = v;
    exp_q.push_back(e);
  endtask

  // Monitor: every change of the output vector must match the next scoreboard entry.
  always begin
    @(negedge clk);
    #1;
    if (mon_en) begin
      mv = out_vec();
      if (mv !== prev_vec) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_change cycle=%0d got=%b", pos_cnt - base, mv);
        end else begin
          me = exp_q.pop_front();
          if ((me.cyc != pos_cnt - base) || (me.vec !== mv)) begin
            failures++;
            $display("FAIL event got cycle=%0d vec=%b expected cycle=%0d vec=%b",
                     pos_cnt - base, mv, me.cyc, me.vec);
          end
        end
        prev_vec = mv;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    rel = pos_cnt - base;
    if (bit_strobe === 1'b1) strobe_cnt++;
  endtask

  // mode 0: single last byte, 1: byte_valid never set, 2: two bytes (second one last)
  task automatic run_pkt(input string name, input int ncyc, input int mode,
                         input int stuff_at, input int abort_at, input int rst_at);
    base       = pos_cnt;
    start      = 1'b1;
    byte_valid = (mode != 1);
    last_byte  = (mode == 0);
    strobe_cnt = 0;
    for (int c = 1; c <= ncyc; c++) begin
      step();
      start     = (c == abort_at);
      abort     = (c == abort_at);
      stuff_req = (c == stuff_at);
      n_rst     = !((c >= rst_at) && (c < rst_at + 2));
      if (mode == 2) last_byte = (c >= 65);
    end
    start     = 1'b0;
    abort     = 1'b0;
    stuff_req = 1'b0;
    n_rst     = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s missing_events got=%0d pending required=0 next_cycle=%0d",
               name, exp_q.size(), exp_q[0].cyc);
    end
    exp_q.delete();
  endtask

  initial begin
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if ({out_vec(), bit_strobe} !== 9'h000) begin
          failures++;
          $display("FAIL reset_outputs got=%b required=000000000", {out_vec(), bit_strobe});
        end
      end
      start      = 1'($urandom_range(1));
      byte_valid = 1'($urandom_range(1));
      last_byte  = 1'($urandom_range(1));
      stuff_req  = 1'($urandom_range(1));
      abort      = 1'($urandom_range(1));
    end
    start = 1'b0; byte_valid = 1'b0; last_byte = 1'b0; stuff_req = 1'b0; abort = 1'b0;
    n_rst = 1'b1;
    step();
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_after_reset got=%b required=0", busy);
    end
    prev_vec = 8'h00;
    mon_en   = 1'b1;

    expect_at(1,   8'b11000000);
    expect_at(64,  8'b11000010);
    expect_at(65,  8'b10000000);
    expect_at(129, 8'b10010000);
    expect_at(145, 8'b10001000);
    expect_at(152, 8'b10001001);
    expect_at(153, 8'b00000000);
    run_pkt("one_byte", 170, 0, 0, 0, 100000);
    checks++;
    if (strobe_cnt != 19) begin
      failures++;
      $display("FAIL strobe_count got=%0d required=19", strobe_cnt);
    end

    expect_at(1,   8'b11000000);
    expect_at(64,  8'b11000010);
    expect_at(65,  8'b10000000);
    expect_at(89,  8'b10100000);
    expect_at(97,  8'b10000000);
    expect_at(137, 8'b10010000);
    expect_at(153, 8'b10001000);
    expect_at(160, 8'b10001001);
    expect_at(161, 8'b00000000);
    run_pkt("stuff_mid", 180, 0, 88, 0, 100000);

    expect_at(1,   8'b11000000);
    expect_at(64,  8'b11000010);
    expect_at(65,  8'b10000000);
    expect_at(129, 8'b10100000);
    expect_at(137, 8'b10010000);
    expect_at(153, 8'b10001000);
    expect_at(160, 8'b10001001);
    expect_at(161, 8'b00000000);
    run_pkt("stuff_last", 180, 0, 128, 0, 100000);

    expect_at(1,   8'b11000000);
    expect_at(64,  8'b11000010);
    expect_at(65,  8'b10000000);
    expect_at(128, 8'b10000010);
    expect_at(129, 8'b10000000);
    expect_at(193, 8'b10010000);
    expect_at(209, 8'b10001000);
    expect_at(216, 8'b10001001);
    expect_at(217, 8'b00000000);
    run_pkt("two_byte", 230, 2, 0, 0, 100000);

    expect_at(1,   8'b11000000);
    expect_at(65,  8'b00000100);
    run_pkt("underrun", 100, 1, 0, 0, 100000);

    expect_at(1,   8'b11000000);
    expect_at(64,  8'b11000010);
    expect_at(65,  8'b10000000);
    expect_at(101, 8'b00000000);
    run_pkt("abort_start", 200, 0, 0, 100, 100000);

    expect_at(1,   8'b11000000);
    expect_at(64,  8'b11000010);
    expect_at(65,  8'b10000000);
    expect_at(81,  8'b00000000);
    run_pkt("mid_reset", 150, 0, 0, 0, 80);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
